// File: rtl/count_pulse_gen.sv
// count_pulse_gen
//   Generates one-cycle count-enable pulses for a downstream 4-bit counter,
//   either from a debounced push-button (first press pulse, then auto-repeat
//   while held) or from a free-running prescaled tick.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset, overrides every other input
//   en         block enable; low freezes everything except the synchronizer
//   btn_raw    asynchronous active-high push-button
//   tick_mode  0 = button mode, 1 = prescaled tick mode
//   prescale   tick period minus one (tick mode)
//   pulse_out  registered one-cycle count-enable pulse
//   btn_level  registered debounced button level
//   repeating  registered, high while the FSM sits in REPEAT
module count_pulse_gen #(
    parameter int unsigned DB_CYCLES     = 200000,
    parameter int unsigned HOLD_CYCLES   = 6000000,
    parameter int unsigned REPEAT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_raw,
    input  logic       tick_mode,
    input  logic [7:0] prescale,
    output logic       pulse_out,
    output logic       btn_level,
    output logic       repeating
);

    localparam logic [19:0] DB_LAST   = 20'(DB_CYCLES - 32'd1);
    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 32'd1);
    localparam logic [23:0] REP_LAST  = 24'(REPEAT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    logic [1:0]  sync_r;
    logic        btn_sync_s;
    logic [19:0] db_cnt_r;
    logic [23:0] timer_r;
    logic [7:0]  presc_cnt_r;
    logic        mode_r;
    logic        fire_r;
    state_t      state_r;
    state_t      state_next_s;
    logic        mode_chg_s;
    logic        hold_hit_s;
    logic        rep_hit_s;
    logic        fire_next_s;
    logic        timer_clr_s;

    assign btn_sync_s = sync_r[1];
    assign mode_chg_s = (tick_mode != mode_r);
    // The !fire_r guard keeps two pulses from ever landing back to back,
    // even with HOLD_CYCLES or REPEAT_CYCLES of 1; the >= compare then
    // catches the hit one cycle late instead of missing it.
    assign hold_hit_s = (timer_r >= HOLD_LAST) && !fire_r;
    assign rep_hit_s  = (timer_r >= REP_LAST) && !fire_r;

    // Two-flop synchronizer for the asynchronous button; ignores en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn_raw};
        end
    end

    // Debouncer: level flips after DB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r  <= 20'd0;
            btn_level <= 1'b0;
        end else if (en) begin
            if (btn_sync_s == btn_level) begin
                db_cnt_r <= 20'd0;
            end else if (db_cnt_r >= DB_LAST) begin
                btn_level <= btn_sync_s;
                db_cnt_r  <= 20'd0;
            end else begin
                db_cnt_r <= db_cnt_r + 20'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else if (en) begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; tick mode and any mode change force IDLE.
    always_comb begin
        state_next_s = state_r;
        if (mode_chg_s || tick_mode) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (btn_level) begin
                        state_next_s = PRESSED;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                PRESSED: begin
                    if (!btn_level) begin
                        state_next_s = IDLE;
                    end else if (hold_hit_s) begin
                        state_next_s = REPEAT;
                    end else begin
                        state_next_s = PRESSED;
                    end
                end
                REPEAT: begin
                    if (!btn_level) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = REPEAT;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // FSM output logic: pulse request and interval-timer clear.
    always_comb begin
        fire_next_s = 1'b0;
        timer_clr_s = 1'b0;
        if (mode_chg_s) begin
            timer_clr_s = 1'b1;
        end else if (tick_mode) begin
            // >= so a prescale lowered mid-period still ends the period.
            fire_next_s = (presc_cnt_r >= prescale);
            timer_clr_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    fire_next_s = btn_level;
                    timer_clr_s = 1'b1;
                end
                PRESSED: begin
                    if (!btn_level) begin
                        timer_clr_s = 1'b1;
                    end else if (hold_hit_s) begin
                        fire_next_s = 1'b1;
                        timer_clr_s = 1'b1;
                    end else begin
                        timer_clr_s = 1'b0;
                    end
                end
                REPEAT: begin
                    if (!btn_level) begin
                        timer_clr_s = 1'b1;
                    end else if (rep_hit_s) begin
                        fire_next_s = 1'b1;
                        timer_clr_s = 1'b1;
                    end else begin
                        timer_clr_s = 1'b0;
                    end
                end
                default: begin
                    timer_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Interval timer, prescale counter, mode history and pulse request.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r     <= 24'd0;
            presc_cnt_r <= 8'd0;
            mode_r      <= 1'b0;
            fire_r      <= 1'b0;
        end else if (en) begin
            mode_r <= tick_mode;
            fire_r <= fire_next_s;
            if (timer_clr_s) begin
                timer_r <= 24'd0;
            end else begin
                timer_r <= timer_r + 24'd1;
            end
            if (mode_chg_s || !tick_mode || (presc_cnt_r >= prescale)) begin
                presc_cnt_r <= 8'd0;
            end else begin
                presc_cnt_r <= presc_cnt_r + 8'd1;
            end
        end
    end

    // Output registers; the pulse is dropped while disabled or on a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_out <= 1'b0;
            repeating <= 1'b0;
        end else begin
            repeating <= (state_r == REPEAT);
            if (en && !mode_chg_s) begin
                pulse_out <= fire_r;
            end else begin
                pulse_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_pulse_gen.sv
// Testbench for count_pulse_gen (DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3).
// Expected pulse edge numbers are queued when stimulus is applied and matched
// against each observed pulse; extra or late pulses are reported.
module tb_count_pulse_gen;

    localparam int DB  = 4;
    localparam int HLD = 10;
    localparam int REP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       btn_raw;
    logic       tick_mode;
    logic [7:0] prescale;
    logic       pulse_out;
    logic       btn_level;
    logic       repeating;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int exp_q[$];

    count_pulse_gen #(
        .DB_CYCLES    (DB),
        .HOLD_CYCLES  (HLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_raw  (btn_raw),
        .tick_mode(tick_mode),
        .prescale (prescale),
        .pulse_out(pulse_out),
        .btn_level(btn_level),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every observed pulse must match the next queued edge number.
    always @(negedge clk) begin : mon
        int exp_c;
        if (pulse_out === 1'b1) begin
            if (exp_q.size() > 0) begin
                exp_c = exp_q.pop_front();
                check_eq("pulse_cycle", cyc, exp_c);
            end else begin
                check_eq("spurious_pulse", int'(pulse_out), 0);
            end
        end
    end

    initial begin
        int k;
        int e;
        rst       = 1'b1;
        en        = 1'b1;
        btn_raw   = 1'b0;
        tick_mode = 1'b0;
        prescale  = 8'd0;
        step(3);
        check_eq("rst_pulse", int'(pulse_out), 0);
        check_eq("rst_level", int'(btn_level), 0);
        check_eq("rst_repeat", int'(repeating), 0);
        rst = 1'b0;
        step(2);

        // Clean press: first sampled at edge k, held 8 edges.
        k = cyc + 1;
        exp_q.push_back(k + DB + 3);
        btn_raw = 1'b1;
        step(6);
        check_eq("s1_level_up", int'(btn_level), 1);
        step(2);
        btn_raw = 1'b0;
        check_eq("s1_repeat", int'(repeating), 0);
        step(5);
        check_eq("s1_level_held", int'(btn_level), 1);
        step(1);
        check_eq("s1_level_down", int'(btn_level), 0);
        step(10);
        check_eq("s1_queue_empty", exp_q.size(), 0);

        // Bounce rejection: toggle every 2 cycles for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i >> 1) & 1) != 0;
            step(1);
            check_eq("bounce_level", int'(btn_level), 0);
        end
        btn_raw = 1'b0;
        step(8);

        // Auto-repeat: held 40 edges; release coincides with a repeat hit.
        k = cyc + 1;
        exp_q.push_back(k + 7);
        for (int j = 0; j < 10; j++) exp_q.push_back(k + 17 + 3 * j);
        btn_raw = 1'b1;
        step(17);
        check_eq("s3_repeat_before", int'(repeating), 0);
        step(1);
        check_eq("s3_repeat_on", int'(repeating), 1);
        step(22);
        btn_raw = 1'b0;
        step(9);
        check_eq("s3_repeat_off", int'(repeating), 0);
        step(10);
        check_eq("s3_queue_empty", exp_q.size(), 0);

        // Tick mode: prescale 2, then 0, then back to button mode.
        e = cyc + 1;
        tick_mode = 1'b1;
        prescale  = 8'd2;
        exp_q.push_back(e + 4);
        exp_q.push_back(e + 7);
        exp_q.push_back(e + 10);
        for (int j = 11; j <= 15; j++) exp_q.push_back(e + j);
        step(1);
        check_eq("tick_enter_zero", int'(pulse_out), 0);
        step(9);
        prescale = 8'd0;
        step(6);
        tick_mode = 1'b0;
        step(1);
        check_eq("tick_exit_zero", int'(pulse_out), 0);
        step(5);
        check_eq("s4_queue_empty", exp_q.size(), 0);

        // Enable gap mid-REPEAT, then a reset while the button stays held.
        k = cyc + 1;
        btn_raw = 1'b1;
        exp_q.push_back(k + 7);
        exp_q.push_back(k + 17);
        exp_q.push_back(k + 20);
        exp_q.push_back(k + 28);
        exp_q.push_back(k + 31);
        exp_q.push_back(k + 40);
        step(21);
        en = 1'b0;
        step(3);
        check_eq("en_repeat_hold", int'(repeating), 1);
        check_eq("en_level_hold", int'(btn_level), 1);
        step(2);
        en = 1'b1;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("mid_rst_pulse", int'(pulse_out), 0);
        check_eq("mid_rst_level", int'(btn_level), 0);
        check_eq("mid_rst_repeat", int'(repeating), 0);
        step(9);
        btn_raw = 1'b0;
        step(19);
        check_eq("s5_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count_pulse_gen.md
COUNT_PULSE_GEN -- requirements
Module: count_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, default 200000, meaning consecutive stable cycles required before the debounced level changes (range 1 to 2^20-1).
REQ-002 Parameter HOLD_CYCLES, default 6000000, meaning cycles from first pulse of a press to first auto-repeat pulse (range 1 to 2^24-1).
REQ-003 Parameter REPEAT_CYCLES, default 1500000, meaning cycles between auto-repeat pulses (range 1 to 2^24-1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  block enable; 0 freezes all state except the synchronizer.
REQ-007 btn_raw  input  1  asynchronous push-button input, active-high.
REQ-008 tick_mode  input  1  0 = button mode, 1 = free-running prescaled tick mode.
REQ-009 prescale  input  8  tick period minus one, used in tick mode.
REQ-010 pulse_out  output  1  registered one-cycle count-enable pulse for the downstream 4-bit counter.
REQ-011 btn_level  output  1  registered debounced button level.
REQ-012 repeating  output  1  high while the FSM is in REPEAT.

Function
REQ-013 btn_raw SHALL pass through a 2-flop synchronizer; btn_sync is the second stage.
REQ-014 The debouncer SHALL flip btn_level only after btn_sync differs from btn_level for DB_CYCLES consecutive enabled cycles.
REQ-015 The debounce counter SHALL clear on any cycle where btn_sync equals btn_level, and SHALL clear when btn_level flips.
REQ-016 The FSM SHALL have exactly three states: IDLE, PRESSED and REPEAT.
REQ-017 In IDLE, when btn_level is 1, the FSM SHALL go to PRESSED, assert pulse_out for one cycle, and clear the interval timer.
REQ-018 In PRESSED, when btn_level is 0, the FSM SHALL go to IDLE with no pulse.
REQ-019 In PRESSED, when the timer reaches HOLD_CYCLES-1, the FSM SHALL go to REPEAT, assert pulse_out, and clear the timer.
REQ-020 In REPEAT, when the timer reaches REPEAT_CYCLES-1, the FSM SHALL assert pulse_out and clear the timer.
REQ-021 In REPEAT, when btn_level is 0, the FSM SHALL go to IDLE with no pulse, and release has priority over a coincident repeat pulse.
REQ-022 In PRESSED, release SHALL have priority over a coincident hold expiry.
REQ-023 In tick mode, the FSM SHALL be held in IDLE and pulse_out SHALL assert for one cycle every prescale+1 enabled cycles; prescale=0 gives pulse_out high continuously.
REQ-024 When the prescale value changes, the new value SHALL take effect at the next period boundary (counter compare against the live value).
REQ-025 On any change of tick_mode, the prescale counter and interval timer SHALL clear, the FSM SHALL enter IDLE, and pulse_out SHALL be 0 that cycle.
REQ-026 While en=0, pulse_out SHALL be 0 and the counters, FSM and btn_level SHALL hold their values.
REQ-027 pulse_out SHALL never be high for two consecutive cycles in button mode.
REQ-028 The counters SHALL be sized so that they never wrap within the parameter ranges.
REQ-029 Button-mode latency SHALL be DB_CYCLES+3 edges: btn_raw is first sampled high at edge k and pulse_out is high after edge k+DB_CYCLES+3.

Reset
REQ-030 When rst=1 at a clock edge, all flops SHALL clear: synchronizer=0, btn_level=0, debounce counter=0, timer=0, prescale counter=0, FSM=IDLE, pulse_out=0, repeating=0.
REQ-031 rst SHALL take priority over en and over every other input.
REQ-032 rst asserted mid-press SHALL return the FSM to IDLE; if the button is still held after reset, it SHALL be re-debounced and produce a fresh first pulse.

Verification
All scenarios below use the parameters DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
REQ-033 Clean press: btn_raw 0->1 sampled at edge 0 and held 8 cycles, then released -> exactly one pulse, high after edge 7 only; repeating stays 0.
REQ-034 Bounce rejection: btn_raw toggling every 2 cycles for 20 cycles -> btn_level stays 0 and pulse_out never asserts.
REQ-035 Auto-repeat: btn_raw held 40 cycles -> pulses after edges 7, 17, 20, 23, 26, ...; repeating=1 from edge 17; no pulse after btn_level falls.
REQ-036 Tick mode: tick_mode=1 and prescale=2 -> pulse_out high every 3rd cycle; prescale=0 -> pulse_out high every cycle; the toggle cycle has pulse_out=0.
REQ-037 Enable and reset: en=0 for 5 cycles mid-REPEAT -> no pulses and the timer holds; rst=1 for 1 cycle while held -> all outputs 0, and the next pulse arrives DB_CYCLES+3 cycles after rst is released.
